// File: rtl/sfu_pkg.sv
// Shared types and sizing for the special-function partial-sum accumulator stage.
package sfu_pkg;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 16;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int NPASS_W = 4;
    // Read counter must hold the largest job: 15 passes of DEPTH words.
    localparam int RD_W    = $clog2(15 * DEPTH + 1);
    localparam int WORD_W  = COL * PSUM_BW;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef logic signed [PSUM_BW-1:0] lane_t;
endpackage

// File: rtl/sfu_psum_accum_lane.sv
// One lane: signed saturating accumulate (or overwrite on the first pass) and ReLU.
// Purely combinational; the write and read-out entries are independent.
module sfu_lane
    import sfu_pkg::*;
(
    input  lane_t acc_in,
    input  lane_t data_in,
    input  logic  overwrite,
    input  lane_t relu_in,
    output lane_t sum_out,
    output lane_t relu_out
);
    logic [PSUM_BW:0] wide;

    always_comb begin
        wide    = {acc_in[PSUM_BW-1], acc_in} + {data_in[PSUM_BW-1], data_in};
        sum_out = wide[PSUM_BW-1:0];
        if (overwrite) begin
            sum_out = data_in;
        end else if (wide[PSUM_BW] != wide[PSUM_BW-1]) begin
            // Sign of the extended sum tells which rail was crossed.
            sum_out = wide[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        end
        relu_out = relu_in[PSUM_BW-1] ? '0 : relu_in;
    end
endmodule

// File: rtl/sfu_psum_accum.sv
// Drains partial-sum words from the output FIFO, accumulates them per pixel over
// num_pass passes with saturation, then streams ReLU'd pixels, one per cycle.
module sfu_psum_accum
    import sfu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NPASS_W-1:0] num_pass,
    input  logic [WORD_W-1:0]  fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_addr,
    output logic [WORD_W-1:0]  out_data,
    output logic               busy,
    output logic               done
);
    localparam logic [IDX_W:0]   FLUSH_END = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    state_t               state_q, state_d;
    logic [NPASS_W-1:0]   num_pass_q, num_pass_d;
    logic [RD_W-1:0]      reads_issued_q, reads_issued_d;
    logic                 rd_d1_q, rd_d1_d;
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic [NPASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [IDX_W:0]       flush_cnt_q, flush_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [IDX_W-1:0]     out_addr_q, out_addr_d;
    logic [WORD_W-1:0]    out_data_q, out_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WORD_W-1:0]    acc_q [DEPTH];
    logic [WORD_W-1:0]    acc_wr_dat;
    logic [WORD_W-1:0]    relu_dat;
    logic [RD_W-1:0]      reads_total;
    logic                 first_pass;

    assign reads_total = RD_W'(num_pass_q) << IDX_W;
    assign first_pass  = (pass_cnt_q == '0);
    assign fifo_rd     = (state_q == RUN) && !fifo_empty && (reads_issued_q < reads_total);

    for (genvar k = 0; k < COL; k++) begin : g_lane
        sfu_lane u_lane (
            .acc_in   (acc_q[wr_idx_q][k*PSUM_BW +: PSUM_BW]),
            .data_in  (fifo_data[k*PSUM_BW +: PSUM_BW]),
            .overwrite(first_pass),
            .relu_in  (acc_q[flush_cnt_q[IDX_W-1:0]][k*PSUM_BW +: PSUM_BW]),
            .sum_out  (acc_wr_dat[k*PSUM_BW +: PSUM_BW]),
            .relu_out (relu_dat[k*PSUM_BW +: PSUM_BW])
        );
    end

    always_comb begin
        state_d        = state_q;
        num_pass_d     = num_pass_q;
        reads_issued_d = reads_issued_q;
        rd_d1_d        = fifo_rd;
        wr_idx_d       = wr_idx_q;
        pass_cnt_d     = pass_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        out_valid_d    = 1'b0;
        out_addr_d     = out_addr_q;
        out_data_d     = out_data_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q blocks a start that lands on the completion cycle.
                if (start && !done_q) begin
                    state_d        = RUN;
                    num_pass_d     = (num_pass == '0) ? NPASS_W'(1) : num_pass;
                    reads_issued_d = '0;
                    wr_idx_d       = '0;
                    pass_cnt_d     = '0;
                    flush_cnt_d    = '0;
                    busy_d         = 1'b1;
                end
            end
            RUN: begin
                if (fifo_rd) begin
                    reads_issued_d = reads_issued_q + RD_W'(1);
                end
                if (rd_d1_q) begin
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        pass_cnt_d = pass_cnt_q + NPASS_W'(1);
                        if (pass_cnt_q == num_pass_q - NPASS_W'(1)) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q < FLUSH_END) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = flush_cnt_q[IDX_W-1:0];
                    out_data_d  = relu_dat;
                    flush_cnt_d = flush_cnt_q + (IDX_W+1)'(1);
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            num_pass_q     <= '0;
            reads_issued_q <= '0;
            rd_d1_q        <= 1'b0;
            wr_idx_q       <= '0;
            pass_cnt_q     <= '0;
            flush_cnt_q    <= '0;
            out_valid_q    <= 1'b0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_pass_q     <= num_pass_d;
            reads_issued_q <= reads_issued_d;
            rd_d1_q        <= rd_d1_d;
            wr_idx_q       <= wr_idx_d;
            pass_cnt_q     <= pass_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            out_valid_q    <= out_valid_d;
            out_addr_q     <= out_addr_d;
            out_data_q     <= out_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Accumulator contents need no reset: pass 0 overwrites every entry.
    always_ff @(posedge clk) begin
        if (rd_d1_q) begin
            acc_q[wr_idx_q] <= acc_wr_dat;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_sfu_psum_accum.sv
// Directed scoreboard bench for sfu_psum_accum with a behavioural FIFO in front.
module tb_sfu_psum_accum;
    import sfu_pkg::*;

    typedef struct {
        logic [IDX_W-1:0]  addr;
        logic [WORD_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [NPASS_W-1:0] num_pass;
    logic [WORD_W-1:0]  fifo_data = {4{32'hDEADBEEF}};
    logic               fifo_empty = 1'b1;
    logic               fifo_rd;
    logic               out_valid;
    logic [IDX_W-1:0]   out_addr;
    logic [WORD_W-1:0]  out_data;
    logic               busy;
    logic               done;

    logic [WORD_W-1:0]  fifo_q [$];
    logic [WORD_W-1:0]  job_w  [$];
    exp_t               exp_q  [$];
    exp_t               mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int rd_when_empty = 0;
    int cyc_no = 0;
    int last_valid_cyc = 0;
    bit gap_en = 1'b0;
    bit gap_phase = 1'b0;
    bit rd_pending = 1'b0;

    sfu_psum_accum dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pass  (num_pass),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO: flags change at negedge, read strobe sampled just after, data popped at posedge.
    always @(negedge clk) begin
        gap_phase  = ~gap_phase;
        fifo_empty = (fifo_q.size() == 0) || (gap_en && gap_phase);
        #1;
        rd_pending = fifo_rd;
        if (fifo_rd) rd_cnt++;
        if (fifo_rd && fifo_empty) rd_when_empty++;
    end

    always @(posedge clk) begin
        cyc_no++;
        if (rd_pending && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_addr", out_addr, mon_e.addr);
                check($sformatf("out_data@%0d", mon_e.addr), out_data, mon_e.data);
                last_valid_cyc = cyc_no;
            end
        end
    end

    task automatic gen_job(input int kind, input int np);
        logic [WORD_W-1:0] w;
        int p, i;
        job_w.delete();
        for (int n = 0; n < np * DEPTH; n++) begin
            p = n / DEPTH;
            i = n % DEPTH;
            w = '0;
            for (int k = 0; k < COL; k++) begin
                case (kind)
                    0: w[k*PSUM_BW +: PSUM_BW] = 16'(i * k);
                    1: w[k*PSUM_BW +: PSUM_BW] = 16'(1);
                    2: begin
                        if (k == 0) w[k*PSUM_BW +: PSUM_BW] = (p == 0) ? 16'h7FF0 : 16'h0100;
                        else if (k == 1) w[k*PSUM_BW +: PSUM_BW] = (p == 0) ? 16'h8000 : 16'hFFFF;
                        else if (k == 2) w[k*PSUM_BW +: PSUM_BW] = (p == 0) ? 16'(i) : 16'(-2 * i);
                        else w[k*PSUM_BW +: PSUM_BW] = 16'(p + k);
                    end
                    3: w[k*PSUM_BW +: PSUM_BW] = 16'($urandom);
                    default: w[k*PSUM_BW +: PSUM_BW] = 16'(i * 3 + k - 20);
                endcase
            end
            job_w.push_back(w);
        end
    endtask

    // Reference: integer accumulate, clamp to the lane range, then ReLU.
    task automatic model_push(input int np);
        int acc [DEPTH][COL];
        int v, s;
        logic signed [PSUM_BW-1:0] lv;
        exp_t e;
        for (int p = 0; p < np; p++)
            for (int i = 0; i < DEPTH; i++)
                for (int k = 0; k < COL; k++) begin
                    lv = job_w[p*DEPTH + i][k*PSUM_BW +: PSUM_BW];
                    v  = lv;
                    s  = (p == 0) ? v : acc[i][k] + v;
                    if (s > 32767) s = 32767;
                    if (s < -32768) s = -32768;
                    acc[i][k] = s;
                end
        for (int i = 0; i < DEPTH; i++) begin
            e.addr = IDX_W'(i);
            e.data = '0;
            for (int k = 0; k < COL; k++)
                e.data[k*PSUM_BW +: PSUM_BW] = (acc[i][k] > 0) ? 16'(acc[i][k]) : 16'(0);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_fifo_rd"}, fifo_rd, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_addr"}, out_addr, '0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_state"}, dut.state_q, IDLE);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_job(input string tag, input int np_in, input int np_eff, input bit gap, input int restart_at);
        int rd_base, emp_base, c;
        rd_base  = rd_cnt;
        emp_base = rd_when_empty;
        gap_en   = gap;
        model_push(np_eff);
        foreach (job_w[n]) fifo_q.push_back(job_w[n]);
        @(negedge clk);
        num_pass = NPASS_W'(np_in);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1'b1);
        if (restart_at > 0) begin
            c = 0;
            while (rd_cnt - rd_base < restart_at && c < 500) begin @(negedge clk); c++; end
            num_pass = 4'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        c = 0;
        while (done !== 1'b1 && c < 4000) begin @(negedge clk); c++; end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_done_latency"}, cyc_no - last_valid_cyc, 1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_reads"}, rd_cnt - rd_base, np_eff * DEPTH);
        check({tag, "_rd_while_empty"}, rd_when_empty - emp_base, 0);
        check({tag, "_scoreboard_drained"}, exp_q.size(), 0);
        gap_en = 1'b0;
    endtask

    initial begin
        int c;
        reset = 1'b0;
        start = 1'b0;
        num_pass = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        gen_job(0, 1);
        run_job("identity_np1", 1, 1, 1'b0, 0);
        start = 1'b1;
        num_pass = 4'd1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_ignored", busy, 1'b0);

        gen_job(1, 9);
        run_job("ones_np9", 9, 9, 1'b0, 0);

        gen_job(2, 2);
        run_job("saturate_np2", 2, 2, 1'b0, 0);

        gen_job(3, 3);
        run_job("gaps_np3", 3, 3, 1'b1, 0);
        run_job("nogap_np3", 3, 3, 1'b0, 0);

        gen_job(3, 4);
        foreach (job_w[n]) fifo_q.push_back(job_w[n]);
        c = rd_cnt;
        @(negedge clk);
        num_pass = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rd_cnt - c < 20 && cyc_no < 40000) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_mid_run");
        @(negedge clk);
        check_idle_outputs("reset_next_cycle");
        fifo_q.delete();
        reset = 1'b1;
        @(negedge clk);

        gen_job(4, 1);
        run_job("fresh_np1", 1, 1, 1'b0, 0);

        gen_job(3, 2);
        run_job("restart_ignored_np2", 2, 2, 1'b0, 10);

        gen_job(0, 1);
        run_job("np0_as_1", 0, 1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sfu_psum_accum.md
# sfu_psum_accum

Special-function stage directly downstream of the output FIFO. It drains `col`-lane partial-sum words from the FIFO and accumulates them per output pixel across `num_pass` kernel passes, using signed saturating addition. It then applies ReLU and streams the finished pixels, one word per cycle, to the output memory write port. It runs on the same clock as the FIFO read side.

## Interface
- `col`, 8, number of lanes (array columns) per FIFO word
- `psum_bw`, 16, signed width of one lane
- `depth`, 16, output pixels per pass (power of 2; index width `$clog2(depth)`)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; asserting it clears all state
- `start`  in  1  one-cycle pulse; begins a job; ignored while `busy`
- `num_pass`  in  4  passes per job, sampled on `start`; 0 is treated as 1
- `fifo_data`  in  col*psum_bw  FIFO read data; valid the cycle after `fifo_rd`
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd`  out  1  FIFO read strobe
- `out_valid`  out  1  result word valid
- `out_addr`  out  $clog2(depth)  pixel index of the result
- `out_data`  out  col*psum_bw  ReLU'd accumulated result
- `busy`  out  1  high from the cycle after `start` until `done`
- `done`  out  1  one-cycle pulse after the last result word

## Operation
- The FSM has three states: IDLE → RUN on `start`; RUN → FLUSH after the last read's data is accumulated; FLUSH → IDLE after `depth` output words, pulsing `done` on that transition.
- In RUN, `fifo_rd = !fifo_empty && (reads_issued < num_pass*depth)`. No read is issued in IDLE or FLUSH.
- The data-valid flag `rd_d1` is `fifo_rd` delayed one cycle. On `rd_d1`:
  - the lanes of `fifo_data` combine into `acc[wr_idx]`;
  - `wr_idx` increments modulo `depth`;
  - on wrap, `pass_cnt` increments.
- On pass 0, `acc[i]` is overwritten; no separate clear is needed. On later passes, `acc[i] += data`.
- Lane add is signed and saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. It never wraps.
- In FLUSH, `out_addr` runs 0..depth-1 over consecutive cycles. `out_data` lane = max(acc lane, 0). `out_valid` is high for exactly `depth` cycles.
- Counter widths: `reads_issued` is 8 bits (max 15*depth = 240 at the default `depth`; widen it if `depth` is raised); `pass_cnt` is 4 bits.

## Timing
- Reset values:
  - `fifo_rd`, `out_valid`, `busy`, `done` = 0;
  - `out_addr`, `out_data` = 0;
  - state = IDLE; all counters = 0.
  - Accumulator contents are don't-care.
- Read-to-accumulate latency: 1 cycle. The accumulator update is registered, so results are visible 2 cycles after `fifo_rd`.
- FLUSH starts the cycle after the final `rd_d1` write. The first `out_valid` appears 1 cycle after entering FLUSH (registered output).
- `done` is asserted in the cycle after the last `out_valid`. `busy` drops in the same cycle.
- `fifo_empty` gaps stall `fifo_rd` with no loss; accumulation resumes on the next non-empty cycle.
- `start` while `busy`: ignored, with no effect on counters.
- `start` in the same cycle as `done`: ignored; a new `start` is accepted from IDLE only.
- Reset asserted mid-RUN or mid-FLUSH:
  - immediate return to IDLE with outputs zeroed;
  - any read already issued is discarded;
  - the FIFO is reset by the same reset.
- `fifo_data` is sampled only on `rd_d1`. Stale FIFO output on non-read cycles is never accumulated.

## Structure
- Shared package `sfu_pkg`:
  - `state_t` enum {IDLE, RUN, FLUSH};
  - constants `COL`, `PSUM_BW`, `DEPTH`, `IDX_W`;
  - `lane_t` = logic signed [PSUM_BW-1:0].
- Sub-module `sfu_lane`: per-lane combinational saturating add plus ReLU, instantiated `col` times.
- FSM, counters and the accumulator register file live in the top module.

## Test plan
- num_pass=1, FIFO preloaded with 16 words, lane k = pixel*k → out_addr 0..15 carries the same values; `done` follows 1 cycle after out_addr=15.
- num_pass=9, every word has all lanes = 1 → every out lane = 9; exactly 144 `fifo_rd` pulses.
- num_pass=2, lane0 = 0x7FF0 then 0x0100 → out lane0 = 0x7FFF (saturated). Lane1 = 0x8000 + 0xFFFF → negative saturation, ReLU gives 0.
- num_pass=3, `fifo_empty` toggles every other cycle → results identical to the no-gap run; `fifo_rd` is never high while `fifo_empty` is high.
- Reset pulsed at read 20 of a num_pass=4 job → all outputs 0 and state IDLE next cycle. A fresh job with num_pass=1 then produces correct results with no residue.
- `start` re-pulsed mid-RUN → ignored; read count and results unchanged.
